// File: rtl/elastic_fifo_buffer.sv
// elastic_fifo_buffer
//   DEPTH-entry circular FIFO of DATA_W-bit flits using si/ri (upstream) and
//   so/ro (downstream) handshakes. buffer_en gates dequeue only.
//   A full buffer still accepts a flit in a cycle where it is also draining.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   buffer_en   dequeue enable
//   buffer_di   upstream data
//   buffer_si   upstream valid
//   buffer_ri   ready to upstream (combinational on buffer_en/buffer_ro)
//   buffer_ro   downstream ready
//   buffer_so   valid to downstream (registered)
//   buffer_do   head-of-queue data (registered)
//   buffer_cnt  occupancy 0..DEPTH
//   buffer_af   occupancy >= AF_LEVEL
module elastic_fifo_buffer #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     buffer_en,
  input  logic [DATA_W-1:0]        buffer_di,
  input  logic                     buffer_si,
  output logic                     buffer_ri,
  input  logic                     buffer_ro,
  output logic                     buffer_so,
  output logic [DATA_W-1:0]        buffer_do,
  output logic [$clog2(DEPTH):0]   buffer_cnt,
  output logic                     buffer_af
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] AF_CNT   = (PTR_W + 1)'(AF_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    cnt;
  logic              enq;
  logic              deq;

  assign buffer_so  = (cnt != '0);
  // A full buffer frees a slot in the same cycle it drains, so it can
  // accept a new flit then.
  assign buffer_ri  = (cnt < FULL_CNT) || (buffer_en && buffer_ro);
  assign buffer_do  = mem[rd_ptr];
  assign buffer_af  = (cnt >= AF_CNT);
  assign buffer_cnt = cnt;

  assign enq = buffer_si && buffer_ri;
  assign deq = buffer_en && buffer_so && buffer_ro;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
        mem[PTR_W'(i)] <= '0;
      end
    end else begin
      if (enq) begin
        mem[wr_ptr] <= buffer_di;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_elastic_fifo_buffer.sv
// tb_elastic_fifo_buffer
//   Directed bench for elastic_fifo_buffer with DATA_W=64, DEPTH=4, AF_LEVEL=3.
module tb_elastic_fifo_buffer;

  logic        clk;
  logic        reset;
  logic        buffer_en;
  logic [63:0] buffer_di;
  logic        buffer_si;
  logic        buffer_ri;
  logic        buffer_ro;
  logic        buffer_so;
  logic [63:0] buffer_do;
  logic [2:0]  buffer_cnt;
  logic        buffer_af;

  int total = 0;
  int bad   = 0;

  elastic_fifo_buffer #(
    .DATA_W   (64),
    .DEPTH    (4),
    .AF_LEVEL (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .buffer_en  (buffer_en),
    .buffer_di  (buffer_di),
    .buffer_si  (buffer_si),
    .buffer_ri  (buffer_ri),
    .buffer_ro  (buffer_ro),
    .buffer_so  (buffer_so),
    .buffer_do  (buffer_do),
    .buffer_cnt (buffer_cnt),
    .buffer_af  (buffer_af)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Pushes one flit with downstream stalled; buffer must have room.
  task automatic push(input logic [63:0] d);
    buffer_di = d;
    buffer_si = 1'b1;
    cyc();
    buffer_si = 1'b0;
  endtask

  logic [63:0] q[$];
  int          sent;
  int          recv;
  logic        acc;
  logic        dq;

  initial begin
    reset     = 1'b0;
    buffer_en = 1'b1;
    buffer_di = '0;
    buffer_si = 1'b0;
    buffer_ro = 1'b0;
    cyc();
    cyc();

    // Reset state
    check_val("rst_so",  {63'd0, buffer_so}, 64'd0);
    check_val("rst_do",  buffer_do, 64'd0);
    check_val("rst_cnt", {61'd0, buffer_cnt}, 64'd0);
    check_val("rst_af",  {63'd0, buffer_af}, 64'd0);
    check_val("rst_ri",  {63'd0, buffer_ri}, 64'd1);

    // Async reset mid-stream with two flits held
    reset = 1'b1;
    cyc();
    push(64'hB0);
    push(64'hB1);
    check_val("pre_rst_cnt", {61'd0, buffer_cnt}, 64'd2);
    buffer_si = 1'b1;
    buffer_di = 64'hB2;
    reset     = 1'b0;
    #1;
    check_val("arst_so",  {63'd0, buffer_so}, 64'd0);
    check_val("arst_do",  buffer_do, 64'd0);
    check_val("arst_cnt", {61'd0, buffer_cnt}, 64'd0);
    check_val("arst_af",  {63'd0, buffer_af}, 64'd0);
    check_val("arst_ri",  {63'd0, buffer_ri}, 64'd1);
    buffer_si = 1'b0;
    cyc();
    reset = 1'b1;
    #1;
    push(64'hA1);
    check_val("first_so",  {63'd0, buffer_so}, 64'd1);
    check_val("first_do",  buffer_do, 64'hA1);
    check_val("first_cnt", {61'd0, buffer_cnt}, 64'd1);
    buffer_ro = 1'b1;
    cyc();
    check_val("first_drain_cnt", {61'd0, buffer_cnt}, 64'd0);
    check_val("first_drain_so",  {63'd0, buffer_so}, 64'd0);
    buffer_ro = 1'b0;

    // Fill and stall
    for (int k = 0; k < 4; k++) begin
      buffer_di = 64'h11 * 64'(k + 1);
      buffer_si = 1'b1;
      #1;
      check_val("fill_ri", {63'd0, buffer_ri}, 64'd1);
      cyc();
      check_val("fill_cnt", {61'd0, buffer_cnt}, 64'(k + 1));
      check_val("fill_af",  {63'd0, buffer_af}, (k + 1 >= 3) ? 64'd1 : 64'd0);
    end
    buffer_di = 64'h55;
    buffer_si = 1'b1;
    #1;
    check_val("full_ri", {63'd0, buffer_ri}, 64'd0);
    cyc();
    check_val("full_hold_cnt", {61'd0, buffer_cnt}, 64'd4);
    check_val("full_hold_do",  buffer_do, 64'h11);

    // Drain in order; the held 0x55 must not have been captured
    buffer_si = 1'b0;
    buffer_ro = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_val("drain_so", {63'd0, buffer_so}, 64'd1);
      check_val("drain_do", buffer_do, 64'h11 * 64'(k + 1));
      cyc();
    end
    check_val("drained_so",  {63'd0, buffer_so}, 64'd0);
    check_val("drained_cnt", {61'd0, buffer_cnt}, 64'd0);
    check_val("drained_af",  {63'd0, buffer_af}, 64'd0);

    // Full pass-through
    buffer_ro = 1'b0;
    for (int k = 0; k < 4; k++) push(64'h11 * 64'(k + 1));
    buffer_di = 64'h55;
    buffer_si = 1'b1;
    buffer_ro = 1'b1;
    #1;
    check_val("pt_ri", {63'd0, buffer_ri}, 64'd1);
    check_val("pt_do", buffer_do, 64'h11);
    cyc();
    buffer_si = 1'b0;
    check_val("pt_cnt", {61'd0, buffer_cnt}, 64'd4);
    for (int k = 0; k < 4; k++) begin
      check_val("pt_drain_do", buffer_do, 64'h11 * 64'(k + 2));
      cyc();
    end
    check_val("pt_empty_cnt", {61'd0, buffer_cnt}, 64'd0);

    // Enable gating
    buffer_ro = 1'b0;
    push(64'h61);
    push(64'h62);
    buffer_ro = 1'b1;
    buffer_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_val("gate_cnt", {61'd0, buffer_cnt}, 64'd2);
      check_val("gate_do",  buffer_do, 64'h61);
    end
    buffer_en = 1'b1;
    cyc();
    check_val("ungate_cnt", {61'd0, buffer_cnt}, 64'd1);
    check_val("ungate_do",  buffer_do, 64'h62);
    cyc();
    check_val("ungate_empty", {61'd0, buffer_cnt}, 64'd0);

    // Wrap-around stream with random downstream stalls
    q.delete();
    sent = 1;
    recv = 0;
    for (int c = 0; c < 200 && recv < 12; c++) begin
      buffer_si = (sent <= 12);
      buffer_di = 64'(sent);
      buffer_ro = ($urandom_range(0, 3) != 0);
      buffer_en = 1'b1;
      #1;
      check_val("wr_ri", {63'd0, buffer_ri},
                ((q.size() < 4) || buffer_ro) ? 64'd1 : 64'd0);
      check_val("wr_so", {63'd0, buffer_so}, (q.size() != 0) ? 64'd1 : 64'd0);
      acc = buffer_si && buffer_ri;
      dq  = buffer_so && buffer_ro;
      if (dq) check_val("wr_do", buffer_do, q[0]);
      cyc();
      if (dq) begin
        void'(q.pop_front());
        recv++;
      end
      if (acc) begin
        q.push_back(64'(sent));
        sent++;
      end
      check_val("wr_cnt", {61'd0, buffer_cnt}, 64'(q.size()));
      check_val("wr_af",  {63'd0, buffer_af}, (q.size() >= 3) ? 64'd1 : 64'd0);
    end
    buffer_si = 1'b0;
    check_val("wr_recv", 64'(recv), 64'd12);
    check_val("wr_sent", 64'(sent), 64'd13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elastic_fifo_buffer.md
# elastic_fifo_buffer

Parametrised multi-entry elastic buffer for the router datapath. It generalises the single-entry send/ready buffer into a DEPTH-entry circular FIFO of DATA_W-bit flits, using the same si/ri and so/ro handshakes and the same buffer_en dequeue gate. It sits at router input and output ports, where several flits must be absorbed while downstream is stalled. It adds occupancy and almost-full outputs for arbitration and flow-control logic.

## Interface
- DATA_W, 64, flit width in bits
- DEPTH, 4, number of entries; power of two, >= 2
- AF_LEVEL, DEPTH-1, occupancy at or above which buffer_af asserts; range 1..DEPTH
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset; one clock domain only
- buffer_en  input  1  dequeue enable; gates removal only, never enqueue
- buffer_di  input  DATA_W  upstream data
- buffer_si  input  1  upstream valid
- buffer_ri  output  1  ready to upstream
- buffer_ro  input  1  downstream ready
- buffer_so  output  1  valid to downstream
- buffer_do  output  DATA_W  head-of-queue data
- buffer_cnt  output  log2(DEPTH)+1  current occupancy, 0..DEPTH
- buffer_af  output  1  almost full

## Operation
- Storage: DEPTH x DATA_W register array. Write pointer wr_ptr and read pointer rd_ptr are each log2(DEPTH) bits. Occupancy register cnt is log2(DEPTH)+1 bits.
- enq = buffer_si && buffer_ri.
- deq = buffer_en && buffer_so && buffer_ro.
- buffer_so = (cnt != 0).
- buffer_ri = (cnt < DEPTH) || (buffer_en && buffer_ro). Full-buffer pass-through: when full and downstream is draining this cycle, a new flit is accepted in the same cycle.
- buffer_do = mem[rd_ptr], driven combinationally from the registers. It is don't-care-stable when empty and holds the last content.
- buffer_af = (cnt >= AF_LEVEL).
- buffer_cnt = cnt.
- On enq: mem[wr_ptr] <= buffer_di; wr_ptr increments.
- On deq: rd_ptr increments.
- Pointers wrap naturally modulo DEPTH, from DEPTH-1 to 0.
- cnt update:
  - +1 on enq only
  - -1 on deq only
  - unchanged on both or neither
- No bypass. An empty buffer never presents buffer_di on buffer_do in the same cycle.
- Ordering is strictly FIFO: no reordering, no drop, no duplication.
- FSM view (derived from cnt, no separate state register):
  - EMPTY (cnt=0): enq goes to PARTIAL, or to FULL when DEPTH=1 (not legal, since DEPTH >= 2).
  - PARTIAL: enq-only raises cnt; deq-only lowers cnt; both holds cnt.
  - FULL (cnt=DEPTH): deq-only goes to PARTIAL; enq+deq stays FULL.
- Reset (reset=0, asynchronous, at any time including mid-transfer):
  - cnt=0, wr_ptr=0, rd_ptr=0, all mem entries=0.
  - Outputs: buffer_so=0, buffer_do=0, buffer_cnt=0, buffer_af=0 (AF_LEVEL >= 1).
  - buffer_ri=1, since cnt < DEPTH.
  - In-flight flits are discarded.
  - Reset release is sampled synchronously: the first enq can occur on the first rising edge with reset=1.

## Timing
- Latency: a flit accepted at edge t appears on buffer_do with buffer_so=1 after edge t (next cycle), when the buffer was empty.
- Throughput: one flit per cycle sustained in and out, including at full occupancy via pass-through.
- buffer_ri depends combinationally on buffer_en and buffer_ro. buffer_so, buffer_do, buffer_cnt and buffer_af are pure register outputs.
- buffer_en=0 freezes dequeue. Enqueue continues until cnt=DEPTH, then buffer_ri=0.
- Upstream may hold buffer_si=1 with stable data while buffer_ri=0. Data is not captured until buffer_ri=1.
- Simultaneous enq and deq at cnt=DEPTH-1: cnt stays DEPTH-1, and buffer_af follows cnt.

## Test plan
Parameters for all scenarios: DATA_W=64, DEPTH=4, AF_LEVEL=3.
- Reset check: assert reset=0 mid-stream with cnt=2 -> same cycle (async): so=0, do=0, cnt=0, af=0, ri=1. After release, first push 0xA1 -> so=1, do=0xA1 next cycle.
- Fill and stall: ro=0, push 0x11,0x22,0x33,0x44 -> cnt goes 1,2,3,4. af=1 from cnt=3. ri=0 at cnt=4. A fifth push of 0x55 held on si is not captured.
- Drain in order: from full, ro=1, en=1, si=0 -> do shows 0x11,0x22,0x33,0x44 on consecutive cycles. Then so=0, cnt=0, af=0.
- Full pass-through: full with 0x11..0x44, si=1 with data 0x55, ro=1, en=1 -> ri=1 the same cycle, cnt stays 4. Output order is 0x11,0x22,0x33,0x44,0x55.
- Enable gating: cnt=2, ro=1, en=0 for 3 cycles -> cnt unchanged, do stable. Set en=1 -> dequeue resumes next edge.
- Wrap-around: stream 12 flits 0x1..0xC at 1/cycle with random ro stalls and en=1 -> every flit received once, in order. Pointers wrap at least twice. cnt never exceeds 4 and never underflows.
